uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  UART transmit stage that consumes the baud-rate pulse produced by the
//  project's modulo-N counter (its ov output, one clk-cycle pulse per bit
//  period). Serialises a parallel word into an asynchronous frame:
//  start, data LSB-first, optional parity, stop bits.
//  Takes words from the upstream source over a valid/ready handshake and
//  drives the txd line.
// PARAMETERS
//  DATA_BITS  8  data bits per frame, legal 5..9
//  PARITY     0  0 = none, 1 = even, 2 = odd
//  STOP_BITS  1  stop bits per frame, legal 1..2
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          reset, asynchronous, active-low
//  baud_tick  in   1          one-cycle pulse per bit period (counter ov)
//  tx_data    in   DATA_BITS  word to send, sampled on accept
//  tx_valid   in   1          tx_data valid
//  tx_ready   out  1          block can accept a word (state IDLE)
//  txd        out  1          serial line, idle high
//  busy       out  1          frame in progress (= !tx_ready)
//  tx_done    out  1          one-cycle pulse at end of the last stop bit
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, txd=1, tx_done=0, shift/counters=0.
//   After reset: tx_ready=1, busy=0. Reset mid-frame aborts the frame;
//   txd returns high immediately and the word is discarded.
//  tx_ready is combinational: state==IDLE. Accept = tx_valid & tx_ready at
//   a clk edge. On accept: shift<=tx_data, par<=^tx_data (even) or
//   ~^tx_data (odd), state<=SYNC.
//  The FSM advances only on clk edges with baud_tick=1; with baud_tick=0 all
//   state, txd and counters hold. txd is registered.
//   IDLE  : txd=1; baud_tick ignored.
//   SYNC  : tick -> txd<=0, state<=START. Aligns the start bit to the grid.
//   START : tick -> txd<=shift[0], shift>>=1, bit_cnt<=0, state<=DATA.
//   DATA  : tick, bit_cnt<DATA_BITS-1 -> txd<=shift[0], shift>>=1,
//             bit_cnt++.
//           tick, bit_cnt==DATA_BITS-1 -> PARITY!=0: txd<=par, ->PARITY;
//             else txd<=1, stop_cnt<=0, ->STOP.
//   PARITY: tick -> txd<=1, stop_cnt<=0, state<=STOP.
//   STOP  : tick, stop_cnt<STOP_BITS-1 -> stop_cnt++.
//           tick, stop_cnt==STOP_BITS-1 -> tx_done<=1 for one cycle,
//             state<=IDLE.
//  Every txd level lasts exactly one tick interval, except the idle-to-start
//   edge, which occurs at the first tick after accept.
//  Frame length in ticks, accept to IDLE: 2+DATA_BITS+(PARITY!=0)+STOP_BITS.
//  Accept and baud_tick in the same cycle: the accept wins and the tick is
//   not counted. SYNC waits for the next tick.
//  tx_ready rises in the cycle after tx_done is set. A new word can be
//   accepted then, so back-to-back frames have no extra idle bit beyond
//   the SYNC wait.
//  tx_data/tx_valid changes while busy are ignored. Upstream holds
//   tx_valid until it is accepted.
//  bit_cnt width is clog2(DATA_BITS). stop_cnt is 1 bit. No arithmetic
//   overflow is possible within the legal parameter range.
// TESTING
//  1 Reset: rst=0 mid-DATA of a frame -> txd=1, tx_ready=1, tx_done=0 at
//    once; no further line activity after release.
//  2 Default params, tick every 4 clk, send 0x55 -> txd per tick: 0,1,0,1,0,
//    1,0,1,0,1 (start, LSB-first data, stop), then tx_done pulse, then ready.
//  3 PARITY=1: send 0x07 -> parity bit 1. PARITY=2: send 0x07 -> parity
//    bit 0. STOP_BITS=2: txd high for 2 tick periods before tx_done.
//  4 Accept 0xA3 in the same cycle as baud_tick -> txd stays 1 until the
//    next tick, then goes 0. Total 11 ticks (default) from accept to IDLE.
//  5 tx_valid held high with 0x01, then 0xFF -> two frames back to back.
//    The second start bit begins at the first tick after tx_done. Data
//    changes while busy do not corrupt frame 1.
//  6 baud_tick held low for 100 clk mid-DATA -> txd and busy frozen;
//    transmission resumes correctly when ticks restart.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmit stage: serialises a parallel word into start / data (LSB first) /
// optional parity / stop bits, advancing one bit per baud_tick pulse.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SYNC   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    logic [2:0]           state;
    logic [DATA_BITS-1:0] shift;
    logic                 par;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 accept;

    // Handshake: a word moves when tx_valid and tx_ready are both high at a
    // rising clk edge; tx_ready is high only while idle, so data offered
    // during a frame simply waits.
    assign tx_ready = (state == S_IDLE);
    assign busy     = ~tx_ready;
    assign accept   = tx_valid & tx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            shift    <= '0;
            par      <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            txd      <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            // Accept takes priority, so a tick in the accept cycle is dropped
            // and SYNC lines the start bit up with the next one.
            if (accept) begin
                shift <= tx_data;
                par   <= (PARITY == 2) ? ~^tx_data : ^tx_data;
                state <= S_SYNC;
            end else if (baud_tick) begin
                case (state)
                    S_SYNC: begin
                        txd   <= 1'b0;
                        state <= S_START;
                    end
                    S_START: begin
                        txd     <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                    S_DATA: begin
                        if (bit_cnt != LAST_BIT) begin
                            txd     <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (PARITY != 0) begin
                            txd   <= par;
                            state <= S_PARITY;
                        end else begin
                            txd      <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= S_STOP;
                        end
                    end
                    S_PARITY: begin
                        txd      <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= S_STOP;
                    end
                    S_STOP: begin
                        if (stop_cnt != LAST_STOP) begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end else begin
                            tx_done <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                    default: begin
                        txd   <= 1'b1;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
